ex_muldiv: RTL and testbench

Iterative multiply/divide unit for the EX stage. It consumes the operand and control fields that the ID/EX pipeline register presents. It owns the architectural HI/LO registers and executes MULT/MULTU/DIV/DIVU over multiple cycles. It asserts a stall back to the pipeline front end when a later instruction needs HI/LO, or needs the unit, while an operation is in flight.

---
 rtl/ex_muldiv_if.sv | 30 +++
 rtl/ex_muldiv.sv | 175 +++++++++++++++++
 tb/tb_ex_muldiv.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_if.sv
// Pipeline-side bundle for the EX-stage multiply/divide unit.
interface ex_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             rd_req;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             flush;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             stall;

  // Pipeline side drives requests and observes HI/LO and hazards
  modport master (
    output start, op, a, b, rd_req, hi_we, lo_we, wdata, flush,
    input  hi_out, lo_out, busy, stall
  );

  // Unit side
  modport slave (
    input  start, op, a, b, rd_req, hi_we, lo_we, wdata, flush,
    output hi_out, lo_out, busy, stall
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle on magnitudes,
// sign fix-up applied in a final cycle before HI/LO are written.
module ex_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic       clk,
  input logic       rst,
  ex_muldiv_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;

  // acc_hi: product high half / partial remainder
  // acc_lo: multiplier being consumed / dividend shifting into quotient
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opd;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             is_signed;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  logic busy;
  logic start_ok;

  // Operand magnitudes and sign flags captured at start
  always_comb begin
    is_signed = ~bus.op[0];
    sign_a    = is_signed & bus.a[WIDTH-1];
    sign_b    = is_signed & bus.b[WIDTH-1];
    abs_a     = sign_a ? -bus.a : bus.a;
    abs_b     = sign_b ? -bus.b : bus.b;
  end

  // One iteration step for multiply and restoring divide
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opd};
    div_ok   = ~div_diff[WIDTH];
    if (is_div) begin
      step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ok};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction; a zero divisor leaves remainder = |a|, so r_fix restores a
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = neg_q ? -acc_lo : acc_lo;
    r_fix    = neg_r ? -acc_hi : acc_hi;
    if (is_div) begin
      fix_hi = r_fix;
      fix_lo = div0 ? '1 : q_fix;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    start_ok  = bus.start & ~bus.flush;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_CALC;
      S_CALC: begin
        if (bus.flush)              state_nxt = S_IDLE;
        else if (cnt == LAST_STEP)  state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Datapath, counter and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opd    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (start_ok) begin
            cnt    <= '0;
            is_div <= bus.op[1];
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            div0   <= bus.op[1] & (bus.b == '0);
            acc_hi <= '0;
            acc_lo <= bus.op[1] ? abs_a : abs_b;
            opd    <= bus.op[1] ? abs_b : abs_a;
          end
        end
        S_CALC: begin
          if (!bus.flush) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // Hazard outputs
  always_comb begin
    busy      = (state != S_IDLE);
    bus.busy  = busy;
    bus.stall = busy & (bus.start | bus.rd_req | bus.hi_we | bus.lo_we);
  end

  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomised and directed check of ex_muldiv against an arithmetic model.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned tests = 0;
  int unsigned fails = 0;

  ex_muldiv_if #(.WIDTH(32)) bus ();

  ex_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: HI/LO, pending result and edges left until it lands
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_rem = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] p;
    longint x, y;
    int sa, sb;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        x = longint'($signed(a));
        y = longint'($signed(b));
        p = 64'(x * y);
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b10: begin
        if (b == 32'd0) begin
          lo = 32'hFFFFFFFF; hi = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          lo = 32'h80000000; hi = 32'd0;
        end else begin
          sa = $signed(a);
          sb = $signed(b);
          lo = 32'(sa / sb);
          hi = 32'(sa % sb);
        end
      end
      default: begin
        if (b == 32'd0) begin
          lo = 32'hFFFFFFFF; hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // One clock: advance model on the edge, then compare every output
  task automatic tick();
    logic exp_stall;
    @(posedge clk);
    if (rst) begin
      m_hi = '0; m_lo = '0; m_rem = 0;
    end else if (m_rem > 0) begin
      if (bus.flush) m_rem = 0;
      else begin
        m_rem--;
        if (m_rem == 0) begin
          m_hi = p_hi; m_lo = p_lo;
        end
      end
    end else begin
      if (bus.hi_we) m_hi = bus.wdata;
      if (bus.lo_we) m_lo = bus.wdata;
      if (bus.start && !bus.flush) begin
        ref_result(bus.op, bus.a, bus.b, p_hi, p_lo);
        m_rem = 33;
      end
    end
    #1;
    exp_stall = (m_rem > 0) && (bus.start || bus.rd_req || bus.hi_we || bus.lo_we);
    chk("hi_out", bus.hi_out, m_hi);
    chk("lo_out", bus.lo_out, m_lo);
    chk("busy", 32'(bus.busy), 32'(m_rem > 0));
    chk("stall", 32'(bus.stall), 32'(exp_stall));
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.rd_req = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0; bus.flush = 0;
  endtask

  // Directed op with literal result and busy-length checks
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    bus.start = 1; bus.op = op; bus.a = a; bus.b = b;
    tick();
    bus.start = 0;
    n = bus.busy ? 1 : 0;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      tick();
      if (bus.busy) n++;
    end
    chk({name, "_busylen"}, 32'(n), 32'd33);
    chk({name, "_hi"}, bus.hi_out, ehi);
    chk({name, "_lo"}, bus.lo_out, elo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom % 20;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    tick();
    chk("reset_hi", bus.hi_out, 32'd0);
    chk("reset_lo", bus.lo_out, 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    rst = 0;
    tick();

    run_op("multu_7x6", 2'b01, 32'd7, 32'd6, 32'd0, 32'd42);
    run_op("mult_m3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1);
    run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    run_op("div_neg_by0", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);

    // Stall on rd_req and suppressed MTHI while busy
    bus.start = 1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7;
    tick();
    bus.start = 0;
    for (int c = 2; c < 45 && bus.busy; c++) begin
      bus.rd_req = 1;
      bus.hi_we  = (c == 10);
      bus.wdata  = 32'd5;
      tick();
      if (bus.busy) chk("stall_rd", 32'(bus.stall), 32'd1);
    end
    clear_inputs();
    chk("stall_divu_hi", bus.hi_out, 32'd2);
    chk("stall_divu_lo", bus.lo_out, 32'd14);
    tick();

    // Flush keeps the MTLO value
    bus.lo_we = 1; bus.wdata = 32'd9;
    tick();
    bus.lo_we = 0;
    bus.start = 1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd3;
    tick();
    bus.start = 0;
    for (int c = 2; c < 15; c++) tick();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("flush_busy", 32'(bus.busy), 32'd0);
    chk("flush_lo", bus.lo_out, 32'd9);

    // Reset mid-operation
    bus.start = 1; bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd5;
    tick();
    bus.start = 0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_hi", bus.hi_out, 32'd0);
    chk("rst_mid_lo", bus.lo_out, 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);

    // Randomised traffic with hazards, flushes and occasional reset
    for (int c = 0; c < 4000; c++) begin
      bus.start  = ($urandom % 4) == 0;
      bus.op     = 2'($urandom % 4);
      bus.a      = pick();
      bus.b      = pick();
      bus.rd_req = ($urandom % 3) == 0;
      bus.hi_we  = ($urandom % 10) == 0;
      bus.lo_we  = ($urandom % 10) == 0;
      bus.wdata  = $urandom;
      bus.flush  = ($urandom % 80) == 0;
      rst        = ($urandom % 700) == 0;
      tick();
    end
    rst = 0;
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
